mux_tree_pipe: RTL and testbench

- Parametrised, pipelined N-to-1 multiplexer for DW-bit data channels.
- Successor to the fixed 8x1 single-bit mux in the combinational/mux library.
- Built as a radix-2 tree with a register after every level, so it closes timing at wide channel counts.
- Carries a valid flag and a channel tag through the pipeline.
- Adds an auto-scan mode: an internal counter steps through the channels, so serialising sampled buses needs no external select logic.

---
 rtl/mux_tree_pipe.sv | 114 +++++++++++
 tb/tb_mux_tree_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// mux_tree_pipe: pipelined radix-2 NCH:1 mux with valid/tag pipeline and auto-scan select. Rev 1.0
// Optional even-parity output and error injection when MUX_TREE_PIPE_PARITY_EN is defined.
module mux_tree_pipe #(
  parameter int DW  = 8,
  parameter int NCH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH*DW-1:0]        in_data,
  input  logic                     in_valid,
  input  logic [$clog2(NCH)-1:0]   sel,
  input  logic                     scan,
`ifdef MUX_TREE_PIPE_PARITY_EN
  input  logic                     in_parity_err_inj,
  output logic                     out_parity,
`endif
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  output logic [$clog2(NCH)-1:0]   out_sel
);
  localparam int SW  = $clog2(NCH);
  localparam int LAT = SW;
  localparam int NW  = NCH - 1;

  if (NCH < 2 || (NCH & (NCH - 1)) != 0) begin : g_bad_nch
    $error("mux_tree_pipe: NCH must be a power of 2 and >= 2");
  end

  logic [SW-1:0] scan_cnt;
  logic          scan_q;
  logic [SW-1:0] cnt_eff;
  logic [SW-1:0] eff_sel;

  // Entering scan mode restarts the sequence at channel 0 for that very sample.
  assign cnt_eff = (scan && !scan_q) ? '0 : scan_cnt;
  assign eff_sel = scan ? cnt_eff : sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_q   <= 1'b0;
    end else begin
      scan_q <= scan;
      if (scan) begin
        if (in_valid) scan_cnt <= cnt_eff + SW'(1);
        else          scan_cnt <= cnt_eff;
      end
    end
  end

  logic [NW*DW-1:0]  tree_d, tree_q;
  logic [LAT*SW-1:0] tag_d, tag_q;
  logic [LAT-1:0]    vld_d, vld_q;
`ifdef MUX_TREE_PIPE_PARITY_EN
  logic [LAT-1:0]    inj_d, inj_q;
`endif

  // All levels are packed into one word vector; level j starts at word NCH - (NCH >> j).
  for (genvar j = 0; j < SW; j++) begin : g_lvl
    localparam int NOUT = NCH >> (j + 1);
    localparam int OB   = NCH - (NCH >> j);
    localparam int IB   = NCH - ((2 * NCH) >> j);
    logic                 s;
    logic [2*NOUT*DW-1:0] src;
    if (j == 0) begin : g_first
      assign s                = eff_sel[0];
      assign src              = in_data;
      assign tag_d[0 +: SW]   = eff_sel;
      assign vld_d[0]         = in_valid;
`ifdef MUX_TREE_PIPE_PARITY_EN
      assign inj_d[0]         = in_parity_err_inj & in_valid;
`endif
    end else begin : g_next
      assign s                = tag_q[(j-1)*SW + j];
      assign src              = tree_q[IB*DW +: 2*NOUT*DW];
      assign tag_d[j*SW +: SW] = tag_q[(j-1)*SW +: SW];
      assign vld_d[j]         = vld_q[j-1];
`ifdef MUX_TREE_PIPE_PARITY_EN
      assign inj_d[j]         = inj_q[j-1];
`endif
    end
    for (genvar i = 0; i < NOUT; i++) begin : g_word
      assign tree_d[(OB+i)*DW +: DW] = s ? src[(2*i+1)*DW +: DW] : src[(2*i)*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tree_q <= '0;
      tag_q  <= '0;
      vld_q  <= '0;
`ifdef MUX_TREE_PIPE_PARITY_EN
      inj_q  <= '0;
`endif
    end else begin
      tree_q <= tree_d;
      tag_q  <= tag_d;
      vld_q  <= vld_d;
`ifdef MUX_TREE_PIPE_PARITY_EN
      inj_q  <= inj_d;
`endif
    end
  end

  assign out_data  = tree_q[(NW-1)*DW +: DW];
  assign out_sel   = tag_q[(LAT-1)*SW +: SW];
  assign out_valid = vld_q[LAT-1];
`ifdef MUX_TREE_PIPE_PARITY_EN
  assign out_parity = (^out_data) ^ inj_q[LAT-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// tb_mux_tree_pipe: table-driven directed checks of mux_tree_pipe (DW=8/NCH=8) plus an NCH=2 instance.
module tb_mux_tree_pipe;
  localparam int DW  = 8;
  localparam int NCH = 8;
  localparam int SW  = 3;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NCH*DW-1:0] in_data;
  logic              in_valid;
  logic [SW-1:0]     sel;
  logic              scan;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic [SW-1:0]     out_sel;

  logic [7:0] in_data2;
  logic       in_valid2, sel2, scan2;
  logic [3:0] out_data2;
  logic       out_valid2, out_sel2;

`ifdef MUX_TREE_PIPE_PARITY_EN
  logic inj, out_parity, inj2, out_parity2;
`endif

  mux_tree_pipe #(.DW(DW), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .sel(sel), .scan(scan),
`ifdef MUX_TREE_PIPE_PARITY_EN
    .in_parity_err_inj(inj), .out_parity(out_parity),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_sel(out_sel)
  );

  mux_tree_pipe #(.DW(4), .NCH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_valid(in_valid2),
    .sel(sel2), .scan(scan2),
`ifdef MUX_TREE_PIPE_PARITY_EN
    .in_parity_err_inj(inj2), .out_parity(out_parity2),
`endif
    .out_data(out_data2), .out_valid(out_valid2), .out_sel(out_sel2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] bus(input logic [7:0] base);
    logic [NCH*DW-1:0] r;
    for (int k = 0; k < NCH; k++) r[k*DW +: DW] = base + 8'(k);
    return r;
  endfunction

  typedef struct {
    logic       vld;
    logic       scn;
    logic [2:0] s;
    logic [7:0] base;
    logic       ev;
    logic [2:0] es;
    logic [7:0] ed;
    string      tag;
  } vec_t;

  vec_t tbl[$];
  vec_t e;

  function automatic void add(input logic v, input logic sc, input logic [2:0] s,
                              input logic [7:0] b, input logic [2:0] es,
                              input logic [7:0] ed, input string t);
    vec_t r;
    r.vld = v; r.scn = sc; r.s = s; r.base = b;
    r.ev = v; r.es = es; r.ed = ed; r.tag = t;
    tbl.push_back(r);
  endfunction

  logic       v2 [6];
  logic       sc2[6];
  logic       s2 [6];
  logic       es2[6];
  logic [3:0] ed2[6];

  initial begin
    // Vector table: each row is one input cycle and the output it must produce LAT cycles later.
    for (int k = 0; k < 8; k++) add(1'b1, 1'b0, 3'(k), 8'hA0, 3'(k), 8'hA0 + 8'(k), "sweep");
    add(1'b1, 1'b0, 3'd5, 8'hA0, 3'd5, 8'hA5, "bubble0");
    add(1'b0, 1'b0, 3'd5, 8'hA0, 3'd0, 8'h00, "bubble1");
    add(1'b1, 1'b0, 3'd5, 8'hA0, 3'd5, 8'hA5, "bubble2");
    add(1'b1, 1'b0, 3'd5, 8'hA0, 3'd5, 8'hA5, "bubble3");
    add(1'b0, 1'b0, 3'd5, 8'hA0, 3'd0, 8'h00, "bubble4");
    for (int i = 0; i < 10; i++) add(1'b1, 1'b1, 3'd7, 8'h10, 3'(i % 8), 8'h10 + 8'(i % 8), "scan_wrap");
    add(1'b0, 1'b0, 3'd0, 8'h10, 3'd0, 8'h00, "gap");
    add(1'b1, 1'b1, 3'd0, 8'h30, 3'd0, 8'h30, "hold0");
    add(1'b1, 1'b1, 3'd0, 8'h30, 3'd1, 8'h31, "hold1");
    add(1'b1, 1'b1, 3'd0, 8'h30, 3'd2, 8'h32, "hold2");
    add(1'b0, 1'b1, 3'd0, 8'h30, 3'd0, 8'h00, "hold_idle0");
    add(1'b0, 1'b1, 3'd0, 8'h30, 3'd0, 8'h00, "hold_idle1");
    add(1'b1, 1'b1, 3'd0, 8'h30, 3'd3, 8'h33, "hold3");
    add(1'b1, 1'b1, 3'd0, 8'h30, 3'd4, 8'h34, "hold4");
    add(1'b1, 1'b0, 3'd6, 8'h30, 3'd6, 8'h36, "ext_sel6");
    add(1'b1, 1'b1, 3'd6, 8'h30, 3'd0, 8'h30, "rescan0");

    v2  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    sc2 = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    s2  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    es2 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ed2 = '{4'hC, 4'h3, 4'h3, 4'hC, 4'h3, 4'h0};

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; sel = '0; scan = 1'b0;
    in_data2 = 8'h00; in_valid2 = 1'b0; sel2 = 1'b0; scan2 = 1'b0;
`ifdef MUX_TREE_PIPE_PARITY_EN
    inj = 1'b0; inj2 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset_valid", out_valid, 1'b0);
    check("reset_data", out_data, 8'h00);
    check("reset_sel", out_sel, 3'd0);
    check("reset_valid_nch2", out_valid2, 1'b0);
`ifdef MUX_TREE_PIPE_PARITY_EN
    check("reset_parity", out_parity, 1'b0);
`endif

    // Fill the pipe with live samples, then reset mid-stream (reset coincides with in_valid=1).
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_data = bus(8'h55); in_valid = 1'b1; sel = 3'(c + 1); scan = c[0];
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 8'h00);
    check("midrst_sel", out_sel, 3'd0);
    rst_n = 1'b1; in_data = '0; in_valid = 1'b0; sel = '0; scan = 1'b0;
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      check("postrst_valid", out_valid, 1'b0);
      check("postrst_data", out_data, 8'h00);
      check("postrst_sel", out_sel, 3'd0);
    end

    for (int c = 0; c < tbl.size() + LAT; c++) begin
      if (c >= LAT) begin
        e = tbl[c-LAT];
        check({e.tag, "_valid"}, out_valid, e.ev);
        if (e.ev) begin
          check({e.tag, "_sel"}, out_sel, e.es);
          check({e.tag, "_data"}, out_data, e.ed);
        end
      end
      if (c < tbl.size()) begin
        e = tbl[c];
        in_valid = e.vld; scan = e.scn; sel = e.s; in_data = bus(e.base);
      end else begin
        in_valid = 1'b0; scan = 1'b0; sel = '0;
      end
      @(negedge clk);
    end

`ifdef MUX_TREE_PIPE_PARITY_EN
    for (int c = 0; c < 3 + LAT; c++) begin
      if (c == LAT)     check("parity_07", out_parity, 1'b1);
      if (c == LAT + 1) check("parity_03", out_parity, 1'b0);
      if (c == LAT + 2) check("parity_03_inj", out_parity, 1'b1);
      in_valid = (c < 3); scan = 1'b0; sel = 3'd2;
      in_data = (c == 0) ? {NCH{8'h07}} : {NCH{8'h03}};
      inj = (c == 2);
      @(negedge clk);
    end
    inj = 1'b0;
`endif

    // NCH=2 instance: single level, one cycle of latency, scan counter wraps every two samples.
    for (int c = 0; c < 7; c++) begin
      if (c >= 1) begin
        check("nch2_valid", out_valid2, v2[c-1]);
        if (v2[c-1]) begin
          check("nch2_sel", out_sel2, es2[c-1]);
          check("nch2_data", out_data2, ed2[c-1]);
        end
      end
      if (c < 6) begin
        in_data2 = 8'hC3; in_valid2 = v2[c]; scan2 = sc2[c]; sel2 = s2[c];
      end else begin
        in_valid2 = 1'b0; scan2 = 1'b0;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
